// File: rtl/crc_frame_pkg.sv
// Shared definitions for the single-wire CRC frame: state names, line levels,
// default field widths and the frame-length helper used by sender and receiver.
package crc_frame_pkg;

  typedef enum logic [2:0] {IDLE, SOF, INIT, POLY, LEN, DATA} frame_state_t;

  localparam logic START_BIT  = 1'b1;
  localparam logic IDLE_LEVEL = 1'b0;

  localparam int BYTE_WIDTH    = 8;
  localparam int DEF_CRC_WIDTH = 8;
  localparam int DEF_LEN_WIDTH = 8;

  function automatic int frame_bits(input int crc_w, input int len_w, input int n_bytes);
    return 1 + 2 * crc_w + len_w + BYTE_WIDTH * n_bytes;
  endfunction

endpackage

// File: rtl/crc_bit_step.sv
// One-bit MSB-first CRC update, no reflection; the x^W term of poly is implicit.
module crc_bit_step #(
  parameter int CRC_WIDTH = 8
) (
  input  logic [CRC_WIDTH-1:0] crc,
  input  logic [CRC_WIDTH-1:0] poly,
  input  logic                 bit_in,
  output logic [CRC_WIDTH-1:0] crc_next
);

  logic feedback;

  assign feedback = crc[CRC_WIDTH-1] ^ bit_in;
  assign crc_next = {crc[CRC_WIDTH-2:0], 1'b0} ^ (feedback ? poly : '0);

endmodule

// File: rtl/crc_frame_sender.sv
// Serialises START | INIT | POLY | LEN | DATA MSB-first onto ser_out, one bit
// per clk, and computes the reference CRC over the payload bits it emits.
module crc_frame_sender
  import crc_frame_pkg::*;
#(
  parameter int CRC_WIDTH = DEF_CRC_WIDTH,
  parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CRC_WIDTH-1:0] cfg_init,
  input  logic [CRC_WIDTH-1:0] cfg_poly,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic [7:0]           data_byte,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 ser_out,
  output logic                 busy,
  output logic                 done,
  output logic                 underrun,
  output logic [CRC_WIDTH-1:0] crc_ref
);

  // Field shifter is as wide as the widest field; each field is loaded MSB-aligned.
  localparam int FW_A = (CRC_WIDTH > LEN_WIDTH) ? CRC_WIDTH : LEN_WIDTH;
  localparam int FW   = (FW_A > BYTE_WIDTH) ? FW_A : BYTE_WIDTH;
  localparam int CW   = $clog2(FW);

  frame_state_t         state_reg;
  logic [CRC_WIDTH-1:0] init_reg, poly_reg, crc_reg, crc_ref_reg;
  logic [LEN_WIDTH-1:0] len_reg, send_left_reg, recv_left_reg;
  logic [FW-1:0]        shift_reg;
  logic [CW-1:0]        bit_cnt_reg;
  logic [7:0]           hold_reg;
  logic                 hold_full_reg;
  logic                 ser_reg, busy_reg, done_reg, underrun_reg;

  logic [CRC_WIDTH-1:0] crc_step;
  logic [FW-1:0]        init_al, poly_al, len_al, hold_al;
  logic                 xfer, field_last, byte_boundary;

  crc_bit_step #(.CRC_WIDTH(CRC_WIDTH)) u_step (
    .crc      (crc_reg),
    .poly     (poly_reg),
    .bit_in   (ser_reg),
    .crc_next (crc_step)
  );

  assign init_al = FW'(init_reg) << (FW - CRC_WIDTH);
  assign poly_al = FW'(poly_reg) << (FW - CRC_WIDTH);
  assign len_al  = FW'(len_reg) << (FW - LEN_WIDTH);
  assign hold_al = FW'(hold_reg) << (FW - BYTE_WIDTH);

  assign data_ready    = busy_reg & ~hold_full_reg & (recv_left_reg != '0);
  assign xfer          = data_valid & data_ready;
  assign field_last    = (bit_cnt_reg == '0);
  // A byte boundary is the last LEN bit or last bit of a data byte with bytes still to send.
  assign byte_boundary = field_last &
                         (((state_reg == LEN) && (len_reg != '0)) ||
                          ((state_reg == DATA) && (send_left_reg != '0)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      init_reg      <= '0;
      poly_reg      <= '0;
      crc_reg       <= '0;
      crc_ref_reg   <= '0;
      len_reg       <= '0;
      send_left_reg <= '0;
      recv_left_reg <= '0;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      ser_reg       <= IDLE_LEVEL;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      done_reg     <= 1'b0;
      underrun_reg <= 1'b0;

      if (xfer) begin
        hold_reg      <= data_byte;
        hold_full_reg <= 1'b1;
        recv_left_reg <= recv_left_reg - 1'b1;
      end else if (byte_boundary) begin
        hold_full_reg <= 1'b0;
      end

      if (state_reg == DATA) crc_reg <= crc_step;

      case (state_reg)
        IDLE: begin
          if (start) begin
            init_reg      <= cfg_init;
            poly_reg      <= cfg_poly;
            len_reg       <= cfg_len;
            crc_reg       <= cfg_init;
            send_left_reg <= cfg_len;
            recv_left_reg <= cfg_len;
            bit_cnt_reg   <= '0;
            ser_reg       <= START_BIT;
            busy_reg      <= 1'b1;
            state_reg     <= SOF;
          end
        end
        SOF, INIT, POLY, LEN, DATA: begin
          if (!field_last) begin
            ser_reg     <= shift_reg[FW-1];
            shift_reg   <= shift_reg << 1;
            bit_cnt_reg <= bit_cnt_reg - 1'b1;
          end else if (state_reg == SOF) begin
            ser_reg     <= init_al[FW-1];
            shift_reg   <= init_al << 1;
            bit_cnt_reg <= CW'(CRC_WIDTH - 1);
            state_reg   <= INIT;
          end else if (state_reg == INIT) begin
            ser_reg     <= poly_al[FW-1];
            shift_reg   <= poly_al << 1;
            bit_cnt_reg <= CW'(CRC_WIDTH - 1);
            state_reg   <= POLY;
          end else if (state_reg == POLY) begin
            ser_reg     <= len_al[FW-1];
            shift_reg   <= len_al << 1;
            bit_cnt_reg <= CW'(LEN_WIDTH - 1);
            state_reg   <= LEN;
          end else if (!byte_boundary) begin
            ser_reg     <= IDLE_LEVEL;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
            crc_ref_reg <= (state_reg == DATA) ? crc_step : crc_reg;
            state_reg   <= IDLE;
          end else if (hold_full_reg) begin
            ser_reg       <= hold_reg[7];
            shift_reg     <= hold_al << 1;
            bit_cnt_reg   <= CW'(BYTE_WIDTH - 1);
            send_left_reg <= send_left_reg - 1'b1;
            state_reg     <= DATA;
          end else begin
            // Abort; discard anything the source pushed on this same edge.
            ser_reg       <= IDLE_LEVEL;
            busy_reg      <= 1'b0;
            underrun_reg  <= 1'b1;
            hold_full_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ser_out  = ser_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign underrun = underrun_reg;
  assign crc_ref  = crc_ref_reg;

endmodule

// File: tb/tb_crc_frame_sender.sv
// Randomised bench for crc_frame_sender: captures the serial line per frame and
// compares it with a bit-list/CRC reference built from the frame rules.
module tb_crc_frame_sender;
  import crc_frame_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] cfg_init = '0, cfg_poly = '0, cfg_len = '0;
  logic [7:0] data_byte = '0;
  logic       data_valid = 1'b0;
  logic       data_ready, ser_out, busy, done, underrun;
  logic [7:0] crc_ref;

  always #5 clk = ~clk;

  crc_frame_sender #(.CRC_WIDTH(8), .LEN_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_init   (cfg_init),
    .cfg_poly   (cfg_poly),
    .cfg_len    (cfg_len),
    .data_byte  (data_byte),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .ser_out    (ser_out),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun),
    .crc_ref    (crc_ref)
  );

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] payload [256];
  bit         obs_bits[$];
  bit         exp_bits[$];
  int         obs_done, obs_under;
  bit         obs_ready_seen, obs_ended;
  logic       obs_end_ser, obs_end_busy;
  logic [7:0] obs_crc;
  logic [7:0] last_good_crc;

  // Reference line image: header fields MSB-first, then the bytes actually sent.
  task automatic build_expected(input logic [7:0] init, input logic [7:0] poly,
                                input logic [7:0] len, input int nsent);
    exp_bits.delete();
    exp_bits.push_back(1'b1);
    for (int i = 7; i >= 0; i--) exp_bits.push_back(init[i]);
    for (int i = 7; i >= 0; i--) exp_bits.push_back(poly[i]);
    for (int i = 7; i >= 0; i--) exp_bits.push_back(len[i]);
    for (int k = 0; k < nsent; k++)
      for (int i = 7; i >= 0; i--) exp_bits.push_back(payload[k][i]);
  endtask

  function automatic logic [7:0] model_crc(input logic [7:0] init, input logic [7:0] poly,
                                           input int len);
    int c = init;
    for (int k = 0; k < len; k++)
      for (int i = 7; i >= 0; i--) begin
        int fb = ((c >> 7) & 1) ^ int'(payload[k][i]);
        c = (c * 2) % 256;
        if (fb != 0) c = c ^ int'(poly);
      end
    return 8'(c);
  endfunction

  function automatic int bits_diff();
    int d = 0;
    if (obs_bits.size() != exp_bits.size()) return 9999;
    foreach (obs_bits[i]) if (obs_bits[i] != exp_bits[i]) d++;
    return d;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
      data_valid = 1'b0;
    end
  endtask

  // Called at a negedge: requests a frame, feeds payload[] with random stalls,
  // records ser_out while busy, and stops in the first cycle busy is low.
  task automatic run_frame(input logic [7:0] init, input logic [7:0] poly, input logic [7:0] len,
                           input int supply, input int max_stall,
                           input int mid_start_at, input int rst_at);
    int idx = 0;
    int stall = 0;
    int cyc = 0;
    obs_bits.delete();
    obs_done = 0; obs_under = 0; obs_ready_seen = 0; obs_ended = 0;
    obs_end_ser = 1'bx; obs_end_busy = 1'bx; obs_crc = 'x;
    cfg_init = init; cfg_poly = poly; cfg_len = len;
    start = 1'b1;
    data_valid = 1'b0;
    while (!obs_ended && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (data_ready) obs_ready_seen = 1;
      if (done) obs_done++;
      if (underrun) obs_under++;
      if (busy) obs_bits.push_back(ser_out);
      else begin
        obs_ended = 1;
        obs_end_ser = ser_out;
        obs_end_busy = busy;
        obs_crc = crc_ref;
      end
      start = (cyc == mid_start_at);
      rst_n = (cyc != rst_at);
      cfg_init = 8'($urandom); cfg_poly = 8'($urandom); cfg_len = 8'($urandom);
      if (obs_ended) data_valid = 1'b0;
      else if (stall > 0) begin data_valid = 1'b0; stall--; end
      else data_valid = (idx < supply);
      data_byte = data_valid ? payload[idx] : 8'($urandom);
      if (data_valid && data_ready) begin
        idx++;
        stall = $urandom_range(max_stall, 0);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1;
    cfg_init = 8'hFF; cfg_poly = 8'hFF; cfg_len = 8'h05;
    repeat (2) @(negedge clk);
    vectors++; if (ser_out !== 1'b0) begin miscompares++; $display("FAIL reset_ser: got %b want 0", ser_out); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (data_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", data_ready); end
    vectors++; if (crc_ref !== 8'h00) begin miscompares++; $display("FAIL reset_crc: got %h want 00", crc_ref); end
    $display("reset: ser=%b busy=%b done=%b ready=%b crc=%h", ser_out, busy, done, data_ready, crc_ref);
    rst_n = 1'b1; start = 1'b0;
    idle(2);
  endtask

  task automatic test_empty_frame();
    int d;
    run_frame(8'hA5, 8'h07, 8'h00, 0, 0, 0, 0);
    build_expected(8'hA5, 8'h07, 8'h00, 0);
    d = bits_diff();
    $display("empty: %0d bits done=%0d crc=%h", obs_bits.size(), obs_done, obs_crc);
    vectors++; if (!obs_ended) begin miscompares++; $display("FAIL empty_timeout: frame did not end"); end
    vectors++; if (obs_bits.size() != frame_bits(8, 8, 0)) begin miscompares++; $display("FAIL empty_len: got %0d bits want %0d", obs_bits.size(), frame_bits(8, 8, 0)); end
    vectors++; if (d != 0) begin miscompares++; $display("FAIL empty_bits: %0d bad bits want 0", d); end
    vectors++; if (obs_done != 1) begin miscompares++; $display("FAIL empty_done: got %0d pulses want 1", obs_done); end
    vectors++; if (obs_crc !== 8'hA5) begin miscompares++; $display("FAIL empty_crc: got %h want a5", obs_crc); end
    vectors++; if (obs_ready_seen) begin miscompares++; $display("FAIL empty_ready: data_ready seen 1 want never"); end
    vectors++; if (obs_end_ser !== 1'b0) begin miscompares++; $display("FAIL empty_idle_line: got %b want 0", obs_end_ser); end
    last_good_crc = 8'hA5;
  endtask

  task automatic test_check_vector();
    int d;
    for (int k = 0; k < 9; k++) payload[k] = 8'h31 + 8'(k);
    idle(2);
    run_frame(8'h00, 8'h07, 8'd9, 9, 0, 0, 0);
    build_expected(8'h00, 8'h07, 8'd9, 9);
    d = bits_diff();
    $display("check: %0d bits done=%0d crc=%h", obs_bits.size(), obs_done, obs_crc);
    vectors++; if (obs_bits.size() != 97) begin miscompares++; $display("FAIL check_len: got %0d bits want 97", obs_bits.size()); end
    vectors++; if (d != 0) begin miscompares++; $display("FAIL check_bits: %0d bad bits want 0", d); end
    vectors++; if (obs_done != 1) begin miscompares++; $display("FAIL check_done: got %0d want 1", obs_done); end
    vectors++; if (obs_crc !== 8'hF4) begin miscompares++; $display("FAIL check_crc: got %h want f4", obs_crc); end
    last_good_crc = 8'hF4;
  endtask

  task automatic test_back_to_back();
    int d;
    logic [7:0] i2, p2, want;
    payload[0] = 8'h01;
    idle(2);
    run_frame(8'h00, 8'h07, 8'd1, 1, 0, 0, 0);
    build_expected(8'h00, 8'h07, 8'd1, 1);
    d = bits_diff();
    $display("single: %0d bits done=%0d crc=%h", obs_bits.size(), obs_done, obs_crc);
    vectors++; if (d != 0) begin miscompares++; $display("FAIL single_bits: %0d bad bits want 0", d); end
    vectors++; if (obs_crc !== 8'h07) begin miscompares++; $display("FAIL single_crc: got %h want 07", obs_crc); end
    vectors++; if (obs_done != 1) begin miscompares++; $display("FAIL single_done: got %0d want 1", obs_done); end
    // Next frame is requested in the done cycle itself.
    i2 = 8'($urandom); p2 = 8'($urandom);
    payload[0] = 8'($urandom); payload[1] = 8'($urandom);
    run_frame(i2, p2, 8'd2, 2, 1, 0, 0);
    build_expected(i2, p2, 8'd2, 2);
    want = model_crc(i2, p2, 2);
    d = bits_diff();
    $display("b2b: %0d bits done=%0d crc=%h", obs_bits.size(), obs_done, obs_crc);
    vectors++; if (d != 0) begin miscompares++; $display("FAIL b2b_bits: %0d bad bits want 0", d); end
    vectors++; if (obs_crc !== want) begin miscompares++; $display("FAIL b2b_crc: got %h want %h", obs_crc, want); end
    last_good_crc = want;
  endtask

  task automatic test_underrun();
    int d;
    logic [7:0] i2, p2;
    i2 = 8'($urandom); p2 = 8'($urandom);
    payload[0] = 8'($urandom);
    idle(2);
    run_frame(i2, p2, 8'd2, 1, 0, 0, 0);
    build_expected(i2, p2, 8'd2, 1);
    d = bits_diff();
    $display("underrun: %0d bits under=%0d done=%0d crc=%h", obs_bits.size(), obs_under, obs_done, obs_crc);
    vectors++; if (d != 0) begin miscompares++; $display("FAIL under_bits: %0d bad bits want 0", d); end
    vectors++; if (obs_under != 1) begin miscompares++; $display("FAIL under_pulse: got %0d want 1", obs_under); end
    vectors++; if (obs_done != 0) begin miscompares++; $display("FAIL under_done: got %0d want 0", obs_done); end
    vectors++; if (obs_end_ser !== 1'b0) begin miscompares++; $display("FAIL under_ser: got %b want 0", obs_end_ser); end
    vectors++; if (obs_crc !== last_good_crc) begin miscompares++; $display("FAIL under_crc: got %h want %h", obs_crc, last_good_crc); end
  endtask

  task automatic test_abuse();
    int d;
    logic [7:0] i2, p2, want;
    for (int k = 0; k < 3; k++) payload[k] = 8'($urandom);
    i2 = 8'($urandom); p2 = 8'($urandom);
    idle(2);
    run_frame(i2, p2, 8'd3, 3, 2, 12, 0);
    build_expected(i2, p2, 8'd3, 3);
    want = model_crc(i2, p2, 3);
    d = bits_diff();
    $display("mid_start: %0d bits done=%0d crc=%h", obs_bits.size(), obs_done, obs_crc);
    vectors++; if (d != 0) begin miscompares++; $display("FAIL midstart_bits: %0d bad bits want 0", d); end
    vectors++; if (obs_crc !== want) begin miscompares++; $display("FAIL midstart_crc: got %h want %h", obs_crc, want); end
    // Reset asserted in the fifth data bit; the line must go quiet the next cycle.
    idle(2);
    run_frame(i2, p2, 8'd3, 3, 0, 0, 30);
    build_expected(i2, p2, 8'd3, 3);
    while (exp_bits.size() > 30) void'(exp_bits.pop_back());
    d = bits_diff();
    $display("mid_reset: %0d bits busy=%b ser=%b done=%0d crc=%h", obs_bits.size(), obs_end_busy, obs_end_ser, obs_done, obs_crc);
    vectors++; if (d != 0) begin miscompares++; $display("FAIL rst_prefix: %0d bad bits want 0", d); end
    vectors++; if (obs_end_ser !== 1'b0 || obs_end_busy !== 1'b0) begin miscompares++; $display("FAIL rst_line: ser=%b busy=%b want 0 0", obs_end_ser, obs_end_busy); end
    vectors++; if (obs_done != 0) begin miscompares++; $display("FAIL rst_done: got %0d want 0", obs_done); end
    vectors++; if (obs_crc !== 8'h00) begin miscompares++; $display("FAIL rst_crc: got %h want 00", obs_crc); end
    last_good_crc = 8'h00;
  endtask

  task automatic test_random();
    int d, n;
    logic [7:0] i2, p2, want;
    for (int f = 0; f < 10; f++) begin
      n = $urandom_range(12, 0);
      for (int k = 0; k < n; k++) payload[k] = 8'($urandom);
      i2 = 8'($urandom); p2 = 8'($urandom);
      idle($urandom_range(2, 0));
      run_frame(i2, p2, 8'(n), n, 4, 0, 0);
      build_expected(i2, p2, 8'(n), n);
      want = model_crc(i2, p2, n);
      d = bits_diff();
      $display("random %0d: len=%0d bits=%0d done=%0d crc=%h", f, n, obs_bits.size(), obs_done, obs_crc);
      vectors++; if (d != 0) begin miscompares++; $display("FAIL rand_bits[%0d]: %0d bad bits want 0", f, d); end
      vectors++; if (obs_crc !== want) begin miscompares++; $display("FAIL rand_crc[%0d]: got %h want %h", f, obs_crc, want); end
      vectors++; if (obs_done != 1 || obs_under != 0) begin miscompares++; $display("FAIL rand_end[%0d]: done=%0d under=%0d want 1 0", f, obs_done, obs_under); end
    end
  endtask

  initial begin
    test_reset();
    test_empty_frame();
    test_check_vector();
    test_back_to_back();
    test_underrun();
    test_abuse();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
